// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter.
//   - FSM state encoding (2 bits, kept as plain constants so the encoding
//     stays fixed for the netlists that already depend on it)
//   - line levels for idle, start and stop
//   - counter width helper shared by the bit timer and the bit index
package serial_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_START = 2'd1;
   localparam state_t ST_DATA  = 2'd2;
   localparam state_t ST_STOP  = 2'd3;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer for the serial transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and raises tick in the last count,
// so whoever advances on tick holds each line level exactly CLKS_PER_BIT
// cycles.
// Ports:
//   c     in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   clr   in   restart the bit period from zero (start of a new frame)
//   en    in   count enable (frame in progress)
//   tick  out  high in the final cycle of a bit period
module bit_timer
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic c,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   // cnt and en both come from flops, so tick has no path from any input.
   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_tx_frame.sv
// Parallel-in, serial-out frame transmitter.
// Takes a DATA_W word on a load/ready handshake and sends it as one start
// bit (0), the data LSB first, then STOP_BITS stop bits (1). Every output is
// a flop so the far end's edge-triggered sampler sees clean levels.
// Ports:
//   c      in   clock, rising edge
//   rst    in   asynchronous active-high reset; abandons any frame
//   din    in   word to send, captured only on an accepting edge
//   load   in   send request; accepted when load & ready at an edge
//   ready  out  transmitter idle and able to accept
//   tx     out  serial line, idles high
//   tx_b   out  registered complement of tx
//   busy   out  frame in progress, always ~ready
//   done   out  one-cycle pulse in the first idle cycle after a frame
//
// state  | meaning
// IDLE   | line high, ready=1, waiting for load
// START  | start bit on the line
// DATA   | data bit bit_idx on the line (shreg[0])
// STOP   | stop bit stop_idx on the line
module serial_tx_frame
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic              c,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              load,
   output logic              ready,
   output logic              tx,
   output logic              tx_b,
   output logic              busy,
   output logic              done
);

   localparam int IW = cnt_width(DATA_W);
   localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_W - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt, shifted;
   logic [IW-1:0]     bit_idx, bit_idx_nxt;
   logic              stop_idx, stop_idx_nxt;
   logic              tx_nxt, ready_nxt, done_nxt;
   logic              accept, tick, timer_en;

   assign accept   = load & ready;
   assign timer_en = (state != ST_IDLE);
   assign shifted  = shreg >> 1;

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .c    (c),
      .rst  (rst),
      .clr  (accept),
      .en   (timer_en),
      .tick (tick)
   );

   always_comb begin
      state_nxt    = state;
      shreg_nxt    = shreg;
      bit_idx_nxt  = bit_idx;
      stop_idx_nxt = stop_idx;
      tx_nxt       = tx;
      ready_nxt    = ready;
      done_nxt     = 1'b0;
      case (state)
         ST_IDLE: begin
            tx_nxt = LINE_IDLE;
            if (accept) begin
               shreg_nxt = din;
               state_nxt = ST_START;
               tx_nxt    = START_LVL;
               ready_nxt = 1'b0;
            end
         end
         ST_START: begin
            if (tick) begin
               state_nxt   = ST_DATA;
               bit_idx_nxt = '0;
               tx_nxt      = shreg[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               shreg_nxt = shifted;
               if (bit_idx == LAST_BIT) begin
                  state_nxt    = ST_STOP;
                  stop_idx_nxt = 1'b0;
                  tx_nxt       = STOP_LVL;
               end else begin
                  bit_idx_nxt = bit_idx + 1'b1;
                  tx_nxt      = shifted[0];
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (stop_idx == LAST_STOP) begin
                  // ready and done rise together: this cycle is the one
                  // mandatory idle cycle before the next start bit.
                  state_nxt = ST_IDLE;
                  tx_nxt    = LINE_IDLE;
                  ready_nxt = 1'b1;
                  done_nxt  = 1'b1;
               end else begin
                  stop_idx_nxt = stop_idx + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            tx_nxt    = LINE_IDLE;
            ready_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         tx       <= LINE_IDLE;
         tx_b     <= ~LINE_IDLE;
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         shreg    <= shreg_nxt;
         bit_idx  <= bit_idx_nxt;
         stop_idx <= stop_idx_nxt;
         tx       <= tx_nxt;
         tx_b     <= ~tx_nxt;
         ready    <= ready_nxt;
         busy     <= ~ready_nxt;
         done     <= done_nxt;
      end
   end

endmodule

// File: tb/tb_serial_tx_frame.sv
module tb_serial_tx_frame;

   typedef struct packed {
      logic tx;
      logic done;
   } exp_t;

   logic       c   = 1'b0;
   logic       rst = 1'b0;

   logic [7:0] din_a  = 8'h00;
   logic       load_a = 1'b0;
   logic       ready_a, tx_a, tx_b_a, busy_a, done_a;

   logic [7:0] din_b  = 8'h00;
   logic       load_b = 1'b0;
   logic       ready_b, tx_b, tx_b_b, busy_b, done_b;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   exp_t qa[$];
   exp_t qb[$];

   int acc_a = 0, acc_cyc_a = 0, done_cnt_a = 0, done_cyc_a = 0, prev_done_a = 0;
   int acc_b = 0, acc_cyc_b = 0, done_cnt_b = 0, done_cyc_b = 0;

   serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
      .c(c), .rst(rst), .din(din_a), .load(load_a), .ready(ready_a),
      .tx(tx_a), .tx_b(tx_b_a), .busy(busy_a), .done(done_a)
   );

   serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
      .c(c), .rst(rst), .din(din_b), .load(load_b), .ready(ready_b),
      .tx(tx_b), .tx_b(tx_b_b), .busy(busy_b), .done(done_b)
   );

   always #5 c = ~c;

   // Expected line level and done flag for every cycle of one frame, starting
   // with the cycle right after the accepting edge.
   function automatic void push_frame(input bit sel, input logic [7:0] d,
                                      input int n, input int s);
      exp_t e;
      e.done = 1'b0;
      for (int k = 0; k < 10 + s - 1; k++) begin
         if (k == 0) e.tx = 1'b0;
         else if (k <= 8) e.tx = d[k-1];
         else e.tx = 1'b1;
         for (int j = 0; j < n; j++) begin
            if (sel) qb.push_back(e);
            else qa.push_back(e);
         end
      end
      e.tx   = 1'b1;
      e.done = 1'b1;
      if (sel) qb.push_back(e);
      else qa.push_back(e);
   endfunction

   // Accept detection uses pre-edge values of load/ready.
   always @(posedge c) begin
      cyc = cyc + 1;
      if (!rst && load_a && ready_a) begin
         acc_a++;
         acc_cyc_a = cyc;
         push_frame(1'b0, din_a, 4, 1);
      end
      if (!rst && load_b && ready_b) begin
         acc_b++;
         acc_cyc_b = cyc;
         push_frame(1'b1, din_b, 1, 2);
      end
   end

   // Scoreboard: compare every cycle, away from the active edge.
   always @(negedge c) begin
      exp_t e;
      logic exp_rdy;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         exp_rdy = e.done;
      end else begin
         e.tx = 1'b1; e.done = 1'b0; exp_rdy = 1'b1;
      end
      n_checks += 5;
      if (tx_a !== e.tx) begin
         n_fail++; $display("FAIL a_tx cyc=%0d got %b expected %b", cyc, tx_a, e.tx);
      end
      if (done_a !== e.done) begin
         n_fail++; $display("FAIL a_done cyc=%0d got %b expected %b", cyc, done_a, e.done);
      end
      if (ready_a !== exp_rdy) begin
         n_fail++; $display("FAIL a_ready cyc=%0d got %b expected %b", cyc, ready_a, exp_rdy);
      end
      if (tx_b_a !== ~tx_a) begin
         n_fail++; $display("FAIL a_tx_b_inv cyc=%0d got %b expected %b", cyc, tx_b_a, ~tx_a);
      end
      if (busy_a !== ~ready_a) begin
         n_fail++; $display("FAIL a_busy_inv cyc=%0d got %b expected %b", cyc, busy_a, ~ready_a);
      end
      if (done_a === 1'b1) begin
         prev_done_a = done_cyc_a;
         done_cyc_a  = cyc;
         done_cnt_a++;
      end

      if (qb.size() > 0) begin
         e = qb.pop_front();
         exp_rdy = e.done;
      end else begin
         e.tx = 1'b1; e.done = 1'b0; exp_rdy = 1'b1;
      end
      n_checks += 5;
      if (tx_b !== e.tx) begin
         n_fail++; $display("FAIL b_tx cyc=%0d got %b expected %b", cyc, tx_b, e.tx);
      end
      if (done_b !== e.done) begin
         n_fail++; $display("FAIL b_done cyc=%0d got %b expected %b", cyc, done_b, e.done);
      end
      if (ready_b !== exp_rdy) begin
         n_fail++; $display("FAIL b_ready cyc=%0d got %b expected %b", cyc, ready_b, exp_rdy);
      end
      if (tx_b_b !== ~tx_b) begin
         n_fail++; $display("FAIL b_tx_b_inv cyc=%0d got %b expected %b", cyc, tx_b_b, ~tx_b);
      end
      if (busy_b !== ~ready_b) begin
         n_fail++; $display("FAIL b_busy_inv cyc=%0d got %b expected %b", cyc, busy_b, ~ready_b);
      end
      if (done_b === 1'b1) begin
         done_cyc_b = cyc;
         done_cnt_b++;
      end
   end

   task automatic wait_done_a(input int target, input int budget);
      int n = 0;
      while (done_cnt_a < target && n < budget) begin
         @(negedge c);
         n++;
      end
      n_checks++;
      if (done_cnt_a < target) begin
         n_fail++; $display("FAIL a_done_timeout got %0d pulses expected %0d", done_cnt_a, target);
      end
   endtask

   task automatic send_a(input logic [7:0] d);
      int a0 = acc_a;
      @(negedge c);
      din_a  = d;
      load_a = 1'b1;
      @(negedge c);
      load_a = 1'b0;
      n_checks++;
      if (acc_a !== a0 + 1) begin
         n_fail++; $display("FAIL a_accept got %0d expected %0d", acc_a, a0 + 1);
      end
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      repeat (2) @(negedge c);
      n_checks += 5;
      if (tx_a !== 1'b1)    begin n_fail++; $display("FAIL rst_tx got %b expected 1", tx_a); end
      if (tx_b_a !== 1'b0)  begin n_fail++; $display("FAIL rst_tx_b got %b expected 0", tx_b_a); end
      if (ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b expected 1", ready_a); end
      if (busy_a !== 1'b0)  begin n_fail++; $display("FAIL rst_busy got %b expected 0", busy_a); end
      if (done_a !== 1'b0)  begin n_fail++; $display("FAIL rst_done got %b expected 0", done_a); end
      rst = 1'b0;
      repeat (2) @(negedge c);
   endtask

   task automatic test_frame_a5;
      int d0 = done_cnt_a;
      send_a(8'hA5);
      wait_done_a(d0 + 1, 60);
      n_checks++;
      if (done_cyc_a - acc_cyc_a !== 40) begin
         n_fail++; $display("FAIL a5_latency got %0d expected 40", done_cyc_a - acc_cyc_a);
      end
      repeat (4) @(negedge c);
      n_checks++;
      if (done_cnt_a !== d0 + 1) begin
         n_fail++; $display("FAIL a5_done_once got %0d expected %0d", done_cnt_a, d0 + 1);
      end
   endtask

   task automatic test_load_while_busy;
      int d0 = done_cnt_a;
      int a0;
      send_a(8'hA5);
      a0 = acc_a;
      repeat (18) @(negedge c);
      din_a  = 8'h3C;
      load_a = 1'b1;
      repeat (3) @(negedge c);
      load_a = 1'b0;
      din_a  = 8'h00;
      n_checks++;
      if (acc_a !== a0) begin
         n_fail++; $display("FAIL busy_load_ignored got %0d accepts expected %0d", acc_a, a0);
      end
      wait_done_a(d0 + 1, 60);
      n_checks++;
      if (done_cyc_a - acc_cyc_a !== 40) begin
         n_fail++; $display("FAIL busy_latency got %0d expected 40", done_cyc_a - acc_cyc_a);
      end
      repeat (3) @(negedge c);
   endtask

   task automatic test_back_to_back;
      int a0 = acc_a;
      int d0 = done_cnt_a;
      int first_acc = 0;
      int n = 0;
      @(negedge c);
      din_a  = 8'h01;
      load_a = 1'b1;
      while (acc_a == a0 && n < 5) begin @(negedge c); n++; end
      first_acc = acc_cyc_a;
      din_a = 8'hFF;
      n = 0;
      while (acc_a < a0 + 2 && n < 60) begin @(negedge c); n++; end
      load_a = 1'b0;
      n_checks++;
      if (acc_a !== a0 + 2) begin
         n_fail++; $display("FAIL b2b_accepts got %0d expected %0d", acc_a, a0 + 2);
      end
      n_checks++;
      if (acc_cyc_a - first_acc !== 41) begin
         n_fail++; $display("FAIL b2b_accept_gap got %0d expected 41", acc_cyc_a - first_acc);
      end
      wait_done_a(d0 + 2, 100);
      n_checks++;
      if (done_cyc_a - prev_done_a !== 41) begin
         n_fail++; $display("FAIL b2b_done_gap got %0d expected 41", done_cyc_a - prev_done_a);
      end
      repeat (3) @(negedge c);
   endtask

   task automatic test_fast_two_stop(input logic [7:0] d);
      int d0 = done_cnt_b;
      int a0 = acc_b;
      int n = 0;
      @(negedge c);
      din_b  = d;
      load_b = 1'b1;
      @(negedge c);
      load_b = 1'b0;
      n_checks++;
      if (acc_b !== a0 + 1) begin
         n_fail++; $display("FAIL fast_accept got %0d expected %0d", acc_b, a0 + 1);
      end
      while (done_cnt_b == d0 && n < 30) begin @(negedge c); n++; end
      n_checks++;
      if (done_cnt_b !== d0 + 1) begin
         n_fail++; $display("FAIL fast_done_count got %0d expected %0d", done_cnt_b, d0 + 1);
      end
      n_checks++;
      if (done_cyc_b - acc_cyc_b !== 11) begin
         n_fail++; $display("FAIL fast_latency got %0d expected 11", done_cyc_b - acc_cyc_b);
      end
      repeat (2) @(negedge c);
   endtask

   task automatic test_reset_mid_frame;
      int d0 = done_cnt_a;
      send_a(8'hC3);
      repeat (12) @(negedge c);
      #2;
      rst = 1'b1;
      qa.delete();
      #1;
      n_checks += 5;
      if (tx_a !== 1'b1)    begin n_fail++; $display("FAIL mid_rst_tx got %b expected 1", tx_a); end
      if (tx_b_a !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_tx_b got %b expected 0", tx_b_a); end
      if (ready_a !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b expected 1", ready_a); end
      if (busy_a !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_busy got %b expected 0", busy_a); end
      if (done_a !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_done got %b expected 0", done_a); end
      @(negedge c);
      rst = 1'b0;
      repeat (50) @(negedge c);
      n_checks++;
      if (done_cnt_a !== d0) begin
         n_fail++; $display("FAIL mid_rst_no_done got %0d expected %0d", done_cnt_a, d0);
      end
      send_a(8'h5A);
      wait_done_a(d0 + 1, 60);
      n_checks++;
      if (done_cyc_a - acc_cyc_a !== 40) begin
         n_fail++; $display("FAIL post_rst_latency got %0d expected 40", done_cyc_a - acc_cyc_a);
      end
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_load_while_busy();
      test_back_to_back();
      test_fast_two_stop(8'h00);
      test_fast_two_stop(8'h96);
      test_reset_mid_frame();
      repeat (3) @(negedge c);
      n_checks++;
      if (qa.size() + qb.size() !== 0) begin
         n_fail++; $display("FAIL queue_drain got %0d expected 0", qa.size() + qb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
